// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with forwarding, ALU and iterative mult/div unit with HI/LO
module ex_stage #(
  parameter int WIDTH     = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             regwritee,
  input  logic             memtorege,
  input  logic             memwritee,
  output logic             regwritee_o,
  output logic             memtorege_o,
  output logic             memwritee_o,
  input  logic             alusrce,
  input  logic             regdste,
  input  logic [2:0]       alucontrole,
  input  logic [WIDTH-1:0] rd1e,
  input  logic [WIDTH-1:0] rd2e,
  input  logic [WIDTH-1:0] signimme,
  input  logic [4:0]       rte,
  input  logic [4:0]       rde,
  input  logic [1:0]       forwardae,
  input  logic [1:0]       forwardbe,
  input  logic [WIDTH-1:0] resultw,
  input  logic [WIDTH-1:0] aluoutm,
  input  logic             mdstarte,
  input  logic [1:0]       mdope,
  input  logic             mfhie,
  input  logic             mfloe,
  output logic [WIDTH-1:0] aluoute,
  output logic [WIDTH-1:0] writedatae,
  output logic [4:0]       writerege,
  output logic             zeroe,
  output logic             mdbusy
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_t;
  md_state_t state, state_n;
  logic [WIDTH-1:0] srca, srcb, alu_res, hi, lo, acc_hi, acc_lo, mag_b, a_l;
  logic [WIDTH-1:0] mag_a_in, mag_b_in, step_hi, step_lo, fix_hi, fix_lo;
  logic [WIDTH:0] madd, shl;
  logic [2*WIDTH-1:0] prod, prod_n;
  logic [5:0] cnt;
  logic [1:0] op_l;
  logic sa, sb, sgn_in, is_div, ge, start;
  assign regwritee_o = regwritee;
  assign memtorege_o = memtorege;
  assign memwritee_o = memwritee;
  assign srca = forwardae == 2'b01 ? resultw : forwardae == 2'b10 ? aluoutm : rd1e;
  assign writedatae = forwardbe == 2'b01 ? resultw : forwardbe == 2'b10 ? aluoutm : rd2e;
  assign srcb = alusrce ? signimme : writedatae;
  assign writerege = regdste ? rde : rte;
  assign zeroe = alu_res == '0;
  assign aluoute = mfhie ? hi : mfloe ? lo : alu_res;
  assign mdbusy = state != IDLE;
  always_comb begin
    alu_res = '0;
    case (alucontrole)
      3'b010:  alu_res = srca + srcb;
      3'b110:  alu_res = srca - srcb;
      3'b000:  alu_res = srca & srcb;
      3'b001:  alu_res = srca | srcb;
      3'b100:  alu_res = srca & ~srcb;
      3'b101:  alu_res = srca | ~srcb;
      3'b111:  alu_res = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
      default: alu_res = '0;
    endcase
  end
  assign start = state == IDLE && mdstarte;
  assign sgn_in = ~mdope[0];
  assign mag_a_in = (sgn_in && srca[WIDTH-1]) ? -srca : srca;
  assign mag_b_in = (sgn_in && writedatae[WIDTH-1]) ? -writedatae : writedatae;
  assign is_div = op_l[1];
  assign madd = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
  assign shl = {acc_hi, acc_lo[WIDTH-1]};
  assign ge = shl >= {1'b0, mag_b};
  assign step_hi = is_div ? (ge ? shl[WIDTH-1:0] - mag_b : shl[WIDTH-1:0]) : madd[WIDTH:1];
  assign step_lo = is_div ? {acc_lo[WIDTH-2:0], ge} : {madd[0], acc_lo[WIDTH-1:1]};
  assign prod = {acc_hi, acc_lo};
  assign prod_n = (sa ^ sb) ? -prod : prod;
  assign fix_hi = !is_div ? prod_n[2*WIDTH-1:WIDTH] : mag_b == '0 ? a_l : sa ? -acc_hi : acc_hi;
  assign fix_lo = !is_div ? prod_n[WIDTH-1:0] : mag_b == '0 ? '1 : (sa ^ sb) ? -acc_lo : acc_lo;
  always_comb begin
    state_n = start ? CALC : (state == CALC && cnt == 6'(MD_CYCLES-1)) ? FIX : state == FIX ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
    end else if (start) begin
      a_l    <= srca;
      op_l   <= mdope;
      sa     <= sgn_in & srca[WIDTH-1];
      sb     <= sgn_in & writedatae[WIDTH-1];
      acc_hi <= '0;
      acc_lo <= mag_a_in;
      mag_b  <= mag_b_in;
      cnt    <= '0;
    end else if (state == CALC) begin
      cnt    <= cnt + 6'd1;
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end else if (state == FIX) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage
module tb_ex_stage;
  logic clk = 0, rstn = 0;
  logic regwritee = 0, memtorege = 0, memwritee = 0;
  logic regwritee_o, memtorege_o, memwritee_o;
  logic alusrce = 0, regdste = 0;
  logic [2:0] alucontrole = 3'b010;
  logic [31:0] rd1e = 0, rd2e = 0, signimme = 0, resultw = 0, aluoutm = 0;
  logic [4:0] rte = 0, rde = 0;
  logic [1:0] forwardae = 0, forwardbe = 0, mdope = 0;
  logic mdstarte = 0, mfhie = 0, mfloe = 0;
  logic [31:0] aluoute, writedatae;
  logic [4:0] writerege;
  logic zeroe, mdbusy;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  ex_stage dut (
    .clk(clk), .rstn(rstn),
    .regwritee(regwritee), .memtorege(memtorege), .memwritee(memwritee),
    .regwritee_o(regwritee_o), .memtorege_o(memtorege_o), .memwritee_o(memwritee_o),
    .alusrce(alusrce), .regdste(regdste), .alucontrole(alucontrole),
    .rd1e(rd1e), .rd2e(rd2e), .signimme(signimme), .rte(rte), .rde(rde),
    .forwardae(forwardae), .forwardbe(forwardbe), .resultw(resultw), .aluoutm(aluoutm),
    .mdstarte(mdstarte), .mdope(mdope), .mfhie(mfhie), .mfloe(mfloe),
    .aluoute(aluoute), .writedatae(writedatae), .writerege(writerege),
    .zeroe(zeroe), .mdbusy(mdbusy)
  );
  task automatic wait_idle(input string name, input int exp_cycles);
    int n = 0;
    while (mdbusy && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== exp_cycles) begin
      failures++;
      $display("FAIL %s busy_cycles got=%0d exp=%0d", name, n, exp_cycles);
    end
  endtask
  task automatic start_md(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    forwardae = 0;
    forwardbe = 0;
    rd1e = a;
    rd2e = b;
    mdope = op;
    mdstarte = 1;
    @(negedge clk);
    mdstarte = 0;
  endtask
  task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    mfhie = 1;
    #1;
    checks++;
    if (aluoute !== eh) begin
      failures++;
      $display("FAIL %s hi got=%h exp=%h", name, aluoute, eh);
    end
    mfhie = 0;
    mfloe = 1;
    #1;
    checks++;
    if (aluoute !== el) begin
      failures++;
      $display("FAIL %s lo got=%h exp=%h", name, aluoute, el);
    end
    mfloe = 0;
    #1;
  endtask
  task automatic run_md(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] eh, input logic [31:0] el);
    start_md(a, b, op);
    wait_idle(name, 33);
    check_hilo(name, eh, el);
  endtask
  task automatic test_reset;
    regwritee = 1;
    memwritee = 1;
    rd1e = 32'd2;
    rd2e = 32'd3;
    alucontrole = 3'b010;
    repeat (2) @(negedge clk);
    checks++;
    if (aluoute !== 32'd5 || regwritee_o !== 1'b1 || memwritee_o !== 1'b1 || memtorege_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_comb got=%h/%b%b%b exp=00000005/101", aluoute, regwritee_o, memtorege_o, memwritee_o);
    end
    rstn = 1;
    @(negedge clk);
    checks++;
    if (mdbusy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", mdbusy);
    end
    check_hilo("reset_hilo", 32'd0, 32'd0);
    regwritee = 0;
    memwritee = 0;
    memtorege = 1;
    #1;
    checks++;
    if (memtorege_o !== 1'b1 || regwritee_o !== 1'b0) begin
      failures++;
      $display("FAIL passthru got=%b%b exp=10", memtorege_o, regwritee_o);
    end
    memtorege = 0;
  endtask
  task automatic test_forwarding;
    rd1e = 5;
    aluoutm = 7;
    resultw = 9;
    forwardae = 2'b10;
    alusrce = 1;
    signimme = 3;
    alucontrole = 3'b010;
    #1;
    checks++;
    if (aluoute !== 32'd10) begin
      failures++;
      $display("FAIL fwd_a_mem got=%h exp=%h", aluoute, 32'd10);
    end
    forwardae = 2'b01;
    #1;
    checks++;
    if (aluoute !== 32'd12) begin
      failures++;
      $display("FAIL fwd_a_wb got=%h exp=%h", aluoute, 32'd12);
    end
    forwardae = 2'b11;
    #1;
    checks++;
    if (aluoute !== 32'd8) begin
      failures++;
      $display("FAIL fwd_a_11 got=%h exp=%h", aluoute, 32'd8);
    end
    rd2e = 32'h55;
    forwardbe = 2'b10;
    #1;
    checks++;
    if (writedatae !== 32'd7) begin
      failures++;
      $display("FAIL fwd_b_mem got=%h exp=%h", writedatae, 32'd7);
    end
    forwardbe = 2'b01;
    #1;
    checks++;
    if (writedatae !== 32'd9) begin
      failures++;
      $display("FAIL fwd_b_wb got=%h exp=%h", writedatae, 32'd9);
    end
    forwardbe = 2'b00;
    alusrce = 0;
    #1;
    checks++;
    if (writedatae !== 32'h55 || aluoute !== 32'h5a) begin
      failures++;
      $display("FAIL fwd_b_reg got=%h/%h exp=00000055/0000005a", writedatae, aluoute);
    end
    forwardae = 0;
  endtask
  task automatic test_alu;
    logic [2:0] ops [8];
    logic [31:0] exp [8];
    ops = '{3'b111, 3'b110, 3'b010, 3'b000, 3'b001, 3'b100, 3'b101, 3'b011};
    exp = '{32'd1, 32'hFFFFFFFE, 32'd0, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0};
    rd1e = 32'hFFFFFFFF;
    rd2e = 32'd1;
    alusrce = 0;
    for (int i = 0; i < 8; i++) begin
      alucontrole = ops[i];
      #1;
      checks++;
      if (aluoute !== exp[i] || zeroe !== (exp[i] == 0)) begin
        failures++;
        $display("FAIL alu_op%b got=%h z=%b exp=%h z=%b", ops[i], aluoute, zeroe, exp[i], exp[i] == 0);
      end
    end
    rd1e = 32'd1;
    rd2e = 32'hFFFFFFFF;
    alucontrole = 3'b111;
    #1;
    checks++;
    if (aluoute !== 32'd0) begin
      failures++;
      $display("FAIL alu_slt_pos got=%h exp=%h", aluoute, 32'd0);
    end
    rd1e = 4;
    rd2e = 4;
    alucontrole = 3'b110;
    #1;
    checks++;
    if (aluoute !== 32'd0 || zeroe !== 1'b1) begin
      failures++;
      $display("FAIL alu_sub_eq got=%h z=%b exp=00000000 z=1", aluoute, zeroe);
    end
    regdste = 0;
    rte = 8;
    rde = 3;
    #1;
    checks++;
    if (writerege !== 5'd8) begin
      failures++;
      $display("FAIL wreg_rt got=%0d exp=8", writerege);
    end
    regdste = 1;
    #1;
    checks++;
    if (writerege !== 5'd3) begin
      failures++;
      $display("FAIL wreg_rd got=%0d exp=3", writerege);
    end
    regdste = 0;
  endtask
  task automatic test_mult;
    run_md("mult_neg", 32'hFFFFFFFD, 32'd7, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFEB);
    rd1e = 4;
    rd2e = 4;
    alucontrole = 3'b110;
    mfhie = 1;
    #1;
    checks++;
    if (zeroe !== 1'b1 || aluoute !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL zero_vs_mfhi got=%h z=%b exp=ffffffff z=1", aluoute, zeroe);
    end
    mfhie = 0;
    run_md("multu", 32'hFFFFFFFF, 32'd2, 2'b01, 32'd1, 32'hFFFFFFFE);
  endtask
  task automatic test_div;
    run_md("div_neg", 32'hFFFFFFF9, 32'd2, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("div_ovf", 32'h80000000, 32'hFFFFFFFF, 2'b10, 32'd0, 32'h80000000);
    run_md("divu_zero", 32'd100, 32'd0, 2'b11, 32'd100, 32'hFFFFFFFF);
  endtask
  task automatic test_busy;
    start_md(32'd5, 32'd6, 2'b00);
    repeat (3) @(negedge clk);
    mfhie = 1;
    #1;
    checks++;
    if (aluoute !== 32'd100 || mdbusy !== 1'b1) begin
      failures++;
      $display("FAIL mfhi_busy got=%h busy=%b exp=00000064 busy=1", aluoute, mdbusy);
    end
    mfhie = 0;
    start_md(32'd9, 32'd9, 2'b01);
    wait_idle("busy_ignore", 29);
    check_hilo("busy_ignore", 32'd0, 32'd30);
  endtask
  task automatic test_back_to_back;
    start_md(32'd100, 32'd7, 2'b11);
    wait_idle("b2b_first", 33);
    rd1e = 3;
    rd2e = 4;
    mdope = 2'b01;
    mdstarte = 1;
    check_hilo("b2b_first", 32'd2, 32'd14);
    @(negedge clk);
    mdstarte = 0;
    checks++;
    if (mdbusy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept got=%b exp=1", mdbusy);
    end
    wait_idle("b2b_second", 33);
    check_hilo("b2b_second", 32'd0, 32'd12);
  endtask
  task automatic test_reset_mid;
    start_md(32'd1000, 32'd1000, 2'b01);
    repeat (10) @(negedge clk);
    rstn = 0;
    @(negedge clk);
    rstn = 1;
    checks++;
    if (mdbusy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_busy got=%b exp=0", mdbusy);
    end
    check_hilo("rst_mid", 32'd0, 32'd0);
    run_md("mult_after_rst", 32'd6, 32'd7, 2'b00, 32'd0, 32'd42);
  endtask
  initial begin
    test_reset;
    test_forwarding;
    test_alu;
    test_mult;
    test_div;
    test_busy;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
